sram_port_arbiter: RTL

- N-port, parametrised arbiter that shares one SRAM driver valid/ready port among several masters: CPU SRAM processor, future DMA, and a firmware-upload engine.
- Sits between the per-master SRAM request buses and the 16-bit SRAM driver, replacing today's single hard-wired connection.
- Supports round-robin or fixed-priority arbitration.
- Supports a per-port lock so split transfers (e.g. two 16-bit halves of a 32-bit word) stay atomic.

---
 rtl/sram_port_arbiter.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one valid/ready SRAM driver port among NUM_PORTS
// masters. A transaction is arbitrated in IDLE, issued and held in BUSY until
// the driver completes, then acknowledged for one cycle in DONE. The DONE cycle
// gives the requester time to drop or refresh req_valid before the next
// arbitration. A master that completes with req_lock high keeps ownership for
// its next request, so split transfers stay atomic.
module sram_port_arbiter #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 16,
    parameter int ARB_MODE  = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        req_valid,
    input  logic [NUM_PORTS-1:0]        req_we,
    input  logic [NUM_PORTS-1:0]        req_lock,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]        req_ready,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic [NUM_PORTS-1:0]        grant,
    output logic                        mem_valid,
    input  logic                        mem_ready,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int SUM_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Registered state and outputs
    state_t                 state_r;
    logic [PTR_W-1:0]       rr_ptr_r;
    logic [PTR_W-1:0]       owner_r;
    logic                   lock_r;

    // Next-state values computed combinationally
    state_t                 state_s;
    logic [PTR_W-1:0]       rr_ptr_s;
    logic [PTR_W-1:0]       owner_s;
    logic                   lock_s;
    logic [NUM_PORTS-1:0]   req_ready_s;
    logic [DATA_W-1:0]      rsp_rdata_s;
    logic [NUM_PORTS-1:0]   grant_s;
    logic                   mem_valid_s;
    logic                   mem_we_s;
    logic [ADDR_W-1:0]      mem_addr_s;
    logic [DATA_W-1:0]      mem_wdata_s;

    // Arbitration result
    logic [PTR_W:0]         pick_s;
    logic                   win_found_s;
    logic [PTR_W-1:0]       win_idx_s;

    // One-hot decode of a port index.
    function automatic logic [NUM_PORTS-1:0] onehot(input logic [PTR_W-1:0] idx);
        onehot = NUM_PORTS'(1'b1) << idx;
    endfunction

    // Successor of a port index, wrapping NUM_PORTS-1 back to 0.
    function automatic logic [PTR_W-1:0] next_port(input logic [PTR_W-1:0] idx);
        next_port = (idx == PTR_W'(NUM_PORTS - 1)) ? PTR_W'(0) : idx + PTR_W'(1);
    endfunction

    // Round-robin pick: first valid port scanning upward from ptr with wrap.
    // The scan runs backwards so the earliest port in scan order is written last.
    // Result is {found, index}.
    function automatic logic [PTR_W:0] pick_rr(input logic [NUM_PORTS-1:0] valid,
                                               input logic [PTR_W-1:0]     ptr);
        logic [PTR_W:0]   res;
        logic [SUM_W-1:0] sum;
        logic [PTR_W-1:0] idx;
        res = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + SUM_W'(k);
            sum = (sum >= SUM_W'(NUM_PORTS)) ? sum - SUM_W'(NUM_PORTS) : sum;
            idx = sum[PTR_W-1:0];
            res = valid[idx] ? {1'b1, idx} : res;
        end
        pick_rr = res;
    endfunction

    // Fixed-priority pick: lowest-index valid port. Result is {found, index}.
    function automatic logic [PTR_W:0] pick_fixed(input logic [NUM_PORTS-1:0] valid);
        logic [PTR_W:0] res;
        res = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            res = valid[PTR_W'(k)] ? {1'b1, PTR_W'(k)} : res;
        end
        pick_fixed = res;
    endfunction

    // Next-state and next-output logic of the IDLE/BUSY/DONE controller.
    always_comb begin
        state_s     = state_r;
        rr_ptr_s    = rr_ptr_r;
        owner_s     = owner_r;
        lock_s      = lock_r;
        req_ready_s = req_ready;
        rsp_rdata_s = rsp_rdata;
        grant_s     = grant;
        mem_valid_s = mem_valid;
        mem_we_s    = mem_we;
        mem_addr_s  = mem_addr;
        mem_wdata_s = mem_wdata;
        win_found_s = 1'b0;
        win_idx_s   = '0;
        pick_s      = (ARB_MODE == 1) ? pick_fixed(req_valid) : pick_rr(req_valid, rr_ptr_r);

        case (state_r)
            IDLE: begin
                if (lock_r && req_valid[owner_r]) begin
                    // Locked owner is back: regrant it without arbitration.
                    win_found_s = 1'b1;
                    win_idx_s   = owner_r;
                end else begin
                    // No lock, or the locked owner walked away: drop the lock
                    // and arbitrate normally this same cycle.
                    lock_s      = 1'b0;
                    win_found_s = pick_s[PTR_W];
                    win_idx_s   = pick_s[PTR_W-1:0];
                end

                if (win_found_s) begin
                    mem_valid_s = 1'b1;
                    mem_we_s    = req_we[win_idx_s];
                    mem_addr_s  = req_addr[int'(win_idx_s) * ADDR_W +: ADDR_W];
                    mem_wdata_s = req_wdata[int'(win_idx_s) * DATA_W +: DATA_W];
                    grant_s     = onehot(win_idx_s);
                    owner_s     = win_idx_s;
                    state_s     = BUSY;
                end else begin
                    state_s     = IDLE;
                end
            end

            BUSY: begin
                if (mem_ready) begin
                    mem_valid_s = 1'b0;
                    rsp_rdata_s = mem_rdata;
                    req_ready_s = onehot(owner_r);
                    lock_s      = req_lock[owner_r];
                    // A taken lock freezes the pointer so fairness resumes
                    // where it left off once the locked sequence ends.
                    rr_ptr_s    = req_lock[owner_r] ? rr_ptr_r : next_port(owner_r);
                    state_s     = DONE;
                end else begin
                    state_s     = BUSY;
                end
            end

            DONE: begin
                req_ready_s = '0;
                grant_s     = '0;
                state_s     = IDLE;
            end

            default: begin
                state_s     = IDLE;
                lock_s      = 1'b0;
                req_ready_s = '0;
                grant_s     = '0;
                mem_valid_s = 1'b0;
            end
        endcase
    end

    // State, arbitration bookkeeping and all outputs, cleared asynchronously on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            rr_ptr_r  <= '0;
            owner_r   <= '0;
            lock_r    <= 1'b0;
            req_ready <= '0;
            rsp_rdata <= '0;
            grant     <= '0;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state_r   <= state_s;
            rr_ptr_r  <= rr_ptr_s;
            owner_r   <= owner_s;
            lock_r    <= lock_s;
            req_ready <= req_ready_s;
            rsp_rdata <= rsp_rdata_s;
            grant     <= grant_s;
            mem_valid <= mem_valid_s;
            mem_we    <= mem_we_s;
            mem_addr  <= mem_addr_s;
            mem_wdata <= mem_wdata_s;
        end
    end

endmodule
